ram_sync_param: RTL and testbench

//  Parametrised single-port synchronous RAM that generalises the 16x4 RAM_4bit.

---
 rtl/ram_sync_param_if.sv | 27 ++
 rtl/ram_sync_param.sv | 121 ++++++++++++
 tb/tb_ram_sync_param.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_sync_param_if.sv
// Access bus of the parametrised scratch RAM: request fields from the master,
// registered read data and status back from the RAM.
interface ram_sync_param_if #(
    parameter int unsigned DATA_W = 4,
    parameter int unsigned ADDR_W = 4
);
    logic              write_en;
    logic              read_en;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] data_in;
    logic              clear_req;
    logic [DATA_W-1:0] data_out;
    logic              rd_valid;
    logic              busy;
    logic              clear_done;
    logic              addr_err;

    modport master (
        output write_en, read_en, address, data_in, clear_req,
        input  data_out, rd_valid, busy, clear_done, addr_err
    );

    modport slave (
        input  write_en, read_en, address, data_in, clear_req,
        output data_out, rd_valid, busy, clear_done, addr_err
    );
endinterface

// File: rtl/ram_sync_param.sv
// Parametrised single-port synchronous RAM with registered read, selectable
// read-during-write behaviour and a clear engine that sweeps after reset or on request.
module ram_sync_param #(
    parameter int unsigned       DATA_W    = 4,
    parameter int unsigned       ADDR_W    = 4,
    parameter int unsigned       DEPTH     = 16,
    parameter int unsigned       RDW_MODE  = 0,
    parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    ram_sync_param_if.slave  bus
);
    localparam int unsigned IDX_W       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [IDX_W-1:0] LAST   = IDX_W'(DEPTH - 1);
    localparam bit          WRITE_FIRST = (RDW_MODE == 0);

    typedef enum logic {
        CLEAR,
        READY
    } state_t;

    state_t            state;
    logic [IDX_W-1:0]  ptr;
    logic [DATA_W-1:0] mem [DEPTH];

    logic [DATA_W-1:0] data_out_q;
    logic              rd_valid_q;
    logic              busy_q;
    logic              clear_done_q;
    logic              addr_err_q;

    logic              ready_c;
    logic              in_range_c;
    logic              rd_acc_c;
    logic              wr_acc_c;
    logic              err_c;
    logic [IDX_W-1:0]  idx_c;
    logic [DATA_W-1:0] rd_data_c;

    // Access qualification: requests only count in READY and inside the populated range.
    always_comb begin
        ready_c    = (state == READY);
        in_range_c = ({1'b0, bus.address} < (ADDR_W + 1)'(DEPTH));
        idx_c      = IDX_W'(bus.address);
        rd_acc_c   = ready_c && bus.read_en  && in_range_c;
        wr_acc_c   = ready_c && bus.write_en && in_range_c;
        err_c      = ready_c && (bus.read_en || bus.write_en) && !in_range_c;
        rd_data_c  = (wr_acc_c && WRITE_FIRST) ? bus.data_in : mem[idx_c];
    end

    // Storage array: no reset so it maps onto a plain RAM; the sweep owns it while clearing.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == CLEAR) begin
                mem[ptr] <= CLEAR_VAL;
            end else if (wr_acc_c) begin
                mem[idx_c] <= bus.data_in;
            end
        end
    end

    // Control FSM and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= CLEAR;
            ptr          <= '0;
            data_out_q   <= '0;
            rd_valid_q   <= 1'b0;
            clear_done_q <= 1'b0;
            addr_err_q   <= 1'b0;
            busy_q       <= 1'b1;
        end else begin
            rd_valid_q   <= 1'b0;
            clear_done_q <= 1'b0;
            addr_err_q   <= err_c;

            case (state)
                CLEAR: begin
                    ptr <= ptr + IDX_W'(1);
                    if (ptr == LAST) begin
                        state        <= READY;
                        ptr          <= '0;
                        clear_done_q <= 1'b1;
                        busy_q       <= 1'b0;
                    end
                end
                READY: begin
                    if (bus.clear_req) begin
                        state  <= CLEAR;
                        ptr    <= '0;
                        busy_q <= 1'b1;
                    end
                end
                default: begin
                    state <= CLEAR;
                    ptr   <= '0;
                end
            endcase

            // Reads sampled on a clear_req edge still complete; out-of-range reads return zero.
            if (rd_acc_c) begin
                data_out_q <= rd_data_c;
                rd_valid_q <= 1'b1;
            end else if (err_c && bus.read_en) begin
                data_out_q <= '0;
                rd_valid_q <= 1'b1;
            end
        end
    end

    assign bus.data_out   = data_out_q;
    assign bus.rd_valid   = rd_valid_q;
    assign bus.busy       = busy_q;
    assign bus.clear_done = clear_done_q;
    assign bus.addr_err   = addr_err_q;

    // The sweep finishes and releases busy on the same edge.
    a_done_not_busy: assert property (@(posedge clk) disable iff (rst) clear_done_q |-> !busy_q);

endmodule

// File: tb/tb_ram_sync_param.sv
// Bench for ram_sync_param: two instances (16 words write-first, 12 words read-first)
// share one stimulus stream and are checked every cycle against a behavioural model.
module tb_ram_sync_param;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, write_en, read_en, clear_req;
    logic [3:0] address, data_in;

    ram_sync_param_if #(.DATA_W(4), .ADDR_W(4)) bus_a ();
    ram_sync_param_if #(.DATA_W(4), .ADDR_W(4)) bus_b ();

    assign bus_a.write_en  = write_en;
    assign bus_a.read_en   = read_en;
    assign bus_a.address   = address;
    assign bus_a.data_in   = data_in;
    assign bus_a.clear_req = clear_req;
    assign bus_b.write_en  = write_en;
    assign bus_b.read_en   = read_en;
    assign bus_b.address   = address;
    assign bus_b.data_in   = data_in;
    assign bus_b.clear_req = clear_req;

    ram_sync_param #(.DATA_W(4), .ADDR_W(4), .DEPTH(16), .RDW_MODE(0), .CLEAR_VAL(4'h0))
        dut_a (.clk(clk), .rst(rst), .bus(bus_a));
    ram_sync_param #(.DATA_W(4), .ADDR_W(4), .DEPTH(12), .RDW_MODE(1), .CLEAR_VAL(4'h9))
        dut_b (.clk(clk), .rst(rst), .bus(bus_b));

    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    endtask

    // Behavioural model: per instance, the word array, a sweep counter and expected outputs.
    int unsigned m_depth [2] = '{16, 12};
    int unsigned m_mode  [2] = '{0, 1};
    logic [3:0]  m_cv    [2] = '{4'h0, 4'h9};
    logic [3:0]  m_mem   [2][16];
    bit          m_sweep [2];
    int          m_cnt   [2];
    logic [3:0]  e_dout  [2];
    bit          e_rdv [2], e_busy [2], e_done [2], e_err [2];
    bit          model_on = 1'b0;

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            e_rdv[k]  = 1'b0;
            e_done[k] = 1'b0;
            e_err[k]  = 1'b0;
            if (rst) begin
                m_sweep[k] = 1'b1;
                m_cnt[k]   = 0;
                e_busy[k]  = 1'b1;
                e_dout[k]  = 4'h0;
            end else if (m_sweep[k]) begin
                m_mem[k][m_cnt[k]] = m_cv[k];
                m_cnt[k]++;
                if (m_cnt[k] == int'(m_depth[k])) begin
                    m_sweep[k] = 1'b0;
                    e_busy[k]  = 1'b0;
                    e_done[k]  = 1'b1;
                end
            end else begin
                if (int'(address) >= int'(m_depth[k])) begin
                    if (write_en || read_en) e_err[k] = 1'b1;
                    if (read_en) begin
                        e_dout[k] = 4'h0;
                        e_rdv[k]  = 1'b1;
                    end
                end else begin
                    if (read_en) begin
                        e_rdv[k]  = 1'b1;
                        e_dout[k] = (write_en && m_mode[k] == 0) ? data_in : m_mem[k][address];
                    end
                    if (write_en) m_mem[k][address] = data_in;
                end
                if (clear_req) begin
                    m_sweep[k] = 1'b1;
                    m_cnt[k]   = 0;
                    e_busy[k]  = 1'b1;
                end
            end
        end
        if (rst) model_on = 1'b1;
    end

    logic [3:0] act_dout [2];
    logic       act_rdv [2], act_busy [2], act_done [2], act_err [2];
    assign act_dout[0] = bus_a.data_out;
    assign act_dout[1] = bus_b.data_out;
    assign act_rdv[0]  = bus_a.rd_valid;
    assign act_rdv[1]  = bus_b.rd_valid;
    assign act_busy[0] = bus_a.busy;
    assign act_busy[1] = bus_b.busy;
    assign act_done[0] = bus_a.clear_done;
    assign act_done[1] = bus_b.clear_done;
    assign act_err[0]  = bus_a.addr_err;
    assign act_err[1]  = bus_b.addr_err;

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (model_on) begin
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("dout%0d", k), 8'(act_dout[k]), 8'(e_dout[k]));
                chk($sformatf("rd_valid%0d", k), 8'(act_rdv[k]), 8'(e_rdv[k]));
                chk($sformatf("busy%0d", k), 8'(act_busy[k]), 8'(e_busy[k]));
                chk($sformatf("clear_done%0d", k), 8'(act_done[k]), 8'(e_done[k]));
                chk($sformatf("addr_err%0d", k), 8'(act_err[k]), 8'(e_err[k]));
            end
        end
    end

    int done_a = 0;
    always @(negedge clk) if (bus_a.clear_done === 1'b1) done_a++;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        rst = 1'b0; write_en = 1'b0; read_en = 1'b0; clear_req = 1'b0;
    endtask

    task automatic busy_len(output int n);
        n = 0;
        while (bus_a.busy === 1'b1 && n < 100) begin
            n++;
            tick();
        end
    endtask

    logic [3:0] fill   [16] = '{4'hE, 4'hC, 4'hB, 4'hD, 4'h9, 4'hF, 4'h4, 4'h6,
                                4'h3, 4'h1, 4'h7, 4'h3, 4'h8, 4'hA, 4'hF, 4'h0};
    logic [3:0] rd_adr [5]  = '{4'hA, 4'h4, 4'h6, 4'h9, 4'h5};
    logic [3:0] rd_exp [5]  = '{4'h7, 4'h9, 4'h4, 4'h1, 4'hF};

    initial begin
        int n, d0;
        rst = 1'b1; write_en = 1'b0; read_en = 1'b0; clear_req = 1'b0;
        address = 4'h0; data_in = 4'h0;
        @(negedge clk);
        tick();

        // Reset sweep length, single done pulse, cleared contents
        idle();
        d0 = done_a;
        chk("t1_busy_after_rst", 8'(bus_a.busy), 8'd1);
        busy_len(n);
        chk("t1_busy_len", 8'(n), 8'd16);
        chk("t1_done_at_fall", 8'(bus_a.clear_done), 8'd1);
        tick(); tick();
        chk("t1_done_count", 8'(done_a - d0), 8'd1);
        for (int i = 0; i < 16; i++) begin
            read_en = 1'b1; address = 4'(i);
            tick();
            chk("t1_read_zero", 8'({bus_a.rd_valid, bus_a.data_out}), 8'h10);
        end
        idle();

        // Fill and back-to-back readback
        for (int i = 0; i < 16; i++) begin
            write_en = 1'b1; address = 4'(i); data_in = fill[i];
            tick();
        end
        idle();
        for (int j = 0; j < 5; j++) begin
            read_en = 1'b1; address = rd_adr[j];
            tick();
            chk("t2_readback", 8'({bus_a.rd_valid, bus_a.data_out}), 8'({1'b1, rd_exp[j]}));
        end
        idle();
        tick();
        chk("t2_hold", 8'({bus_a.rd_valid, bus_a.data_out}), 8'h0F);

        // Read-during-write in both modes
        write_en = 1'b1; address = 4'h3; data_in = 4'hD;
        tick();
        write_en = 1'b1; read_en = 1'b1; data_in = 4'h2;
        tick();
        chk("t3_write_first", 8'({bus_a.rd_valid, bus_a.data_out}), 8'h12);
        chk("t3_read_first",  8'({bus_b.rd_valid, bus_b.data_out}), 8'h1D);
        write_en = 1'b0;
        tick();
        chk("t3_after_a", 8'(bus_a.data_out), 8'h2);
        chk("t3_after_b", 8'(bus_b.data_out), 8'h2);
        idle();

        // Accesses during a requested sweep are dropped
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        write_en = 1'b1; read_en = 1'b1; address = 4'h1; data_in = 4'h5;
        n = 0;
        while (bus_a.busy === 1'b1 && n < 100) begin
            chk("t4_no_status", 8'({bus_a.rd_valid, bus_a.addr_err}), 8'h0);
            if (n == 9) begin write_en = 1'b0; read_en = 1'b0; end
            n++;
            tick();
        end
        chk("t4_sweep_len", 8'(n), 8'd16);
        idle();
        read_en = 1'b1; address = 4'h1;
        tick();
        chk("t4_read_cleared", 8'({bus_a.rd_valid, bus_a.data_out}), 8'h10);
        idle();

        // Out-of-range on the 12-word instance
        write_en = 1'b1; address = 4'hC; data_in = 4'h7;
        tick();
        chk("t5_werr", 8'({bus_b.addr_err, bus_b.rd_valid}), 8'h2);
        write_en = 1'b0; read_en = 1'b1;
        tick();
        chk("t5_rerr", 8'({bus_b.addr_err, bus_b.rd_valid, bus_b.data_out}), 8'h30);
        for (int i = 0; i < 12; i++) begin
            address = 4'(i);
            tick();
            chk("t5_words_kept", 8'({bus_b.addr_err, bus_b.rd_valid, bus_b.data_out}), 8'h19);
        end
        idle();

        // Reset in the middle of a sweep restarts it
        d0 = done_a;
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        repeat (7) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        busy_len(n);
        chk("t6_busy_len", 8'(n), 8'd16);
        tick(); tick();
        chk("t6_done_count", 8'(done_a - d0), 8'd1);

        // Randomised traffic against the model
        for (int c = 0; c < 3000; c++) begin
            rst       = ($urandom_range(0, 199) == 0);
            clear_req = ($urandom_range(0, 59) == 0);
            write_en  = 1'($urandom_range(0, 1));
            read_en   = 1'($urandom_range(0, 1));
            address   = 4'($urandom_range(0, 15));
            data_in   = 4'($urandom_range(0, 15));
            tick();
        end
        idle();
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d passed", n_pass, n_total);
        $fatal(1);
    end

endmodule
